// File: rtl/data_mem_unit.sv
// data_mem_unit: RV32I load/store data memory (byte lanes, sign/zero extension, range check, valid/ready).
// Define DATA_MEM_SPLIT_EN to split misaligned accesses across two words instead of faulting.
module data_mem_unit #(
    parameter logic [31:0] ADDR_BASE   = 32'h0100_0000,
    parameter int unsigned DEPTH_WORDS = 65536,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        resp_misalign
);

    localparam logic [32:0] BASE_X = {1'b0, ADDR_BASE};
    localparam logic [32:0] LAST_X = BASE_X + (33'(DEPTH_WORDS) << 2) - 33'd1;

`ifdef DATA_MEM_SPLIT_EN
    typedef enum logic [1:0] {IDLE, RESP, SPLIT} state_t;
`else
    typedef enum logic {IDLE, RESP} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        req_ready_q, req_ready_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic        resp_misalign_q, resp_misalign_d;

    logic             accept_c, enc_ok_c, misalign_c, range_ok_c, fault_c;
    logic [3:0]       size_mask_c;
    logic [32:0]      last_byte_c;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      rd_word_c;

    logic             wr_en_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [3:0]       wr_mask_c;
    logic [31:0]      wr_data_c;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'd0, raw[7:0]};
            3'b101:  extend = {16'd0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Request decode: encoding, size, alignment, 33-bit range check, word index
    always_comb begin
        accept_c = req_valid && req_ready_q;
        enc_ok_c = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3[1:0])
            2'b00:   size_mask_c = 4'b0001;
            2'b01:   size_mask_c = 4'b0011;
            default: size_mask_c = 4'b1111;
        endcase
        misalign_c  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        last_byte_c = {1'b0, req_addr} + {31'd0, size_mask_c[3], size_mask_c[1]};
        range_ok_c  = ({1'b0, req_addr} >= BASE_X) && (last_byte_c <= LAST_X);
        idx_c       = IDX_W'((req_addr - ADDR_BASE) >> 2);
        rd_word_c   = mem_q[idx_c];
    end

`ifdef DATA_MEM_SPLIT_EN
    logic             split_c;
    logic [7:0]       lane_mask_c;
    logic [63:0]      lane_data_c;
    logic [31:0]      rd_hi_c;
    logic [63:0]      pair_c;

    logic             sp_we_q, sp_we_d;
    logic [2:0]       sp_f3_q, sp_f3_d;
    logic [1:0]       sp_off_q, sp_off_d;
    logic [IDX_W-1:0] sp_idx_q, sp_idx_d;
    logic [3:0]       sp_mask_q, sp_mask_d;
    logic [31:0]      sp_data_q, sp_data_d;
    logic [31:0]      sp_lo_q, sp_lo_d;

    // Next state and registered outputs; a misaligned access parks in SPLIT for its second word
    always_comb begin
        fault_c     = !enc_ok_c || !range_ok_c;
        split_c     = !fault_c && misalign_c;
        lane_mask_c = {4'd0, size_mask_c} << req_addr[1:0];
        lane_data_c = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
        rd_hi_c     = mem_q[sp_idx_q];
        pair_c      = {rd_hi_c, sp_lo_q} >> {sp_off_q, 3'b000};

        state_d         = IDLE;
        req_ready_d     = 1'b1;
        resp_rdata_d    = 32'd0;
        resp_fault_d    = 1'b0;
        resp_misalign_d = 1'b0;
        wr_en_c         = 1'b0;
        wr_idx_c        = idx_c;
        wr_mask_c       = lane_mask_c[3:0];
        wr_data_c       = lane_data_c[31:0];
        sp_we_d         = sp_we_q;
        sp_f3_d         = sp_f3_q;
        sp_off_d        = sp_off_q;
        sp_idx_d        = sp_idx_q;
        sp_mask_d       = sp_mask_q;
        sp_data_d       = sp_data_q;
        sp_lo_d         = sp_lo_q;

        if (state_q == SPLIT) begin
            state_d   = RESP;
            wr_en_c   = sp_we_q;
            wr_idx_c  = sp_idx_q;
            wr_mask_c = sp_mask_q;
            wr_data_c = sp_data_q;
            if (!sp_we_q) begin
                resp_rdata_d = extend(32'(pair_c), sp_f3_q);
            end
        end else if (accept_c) begin
            wr_en_c = req_we && !fault_c;
            if (split_c) begin
                state_d     = SPLIT;
                req_ready_d = 1'b0;
                sp_we_d     = req_we;
                sp_f3_d     = req_funct3;
                sp_off_d    = req_addr[1:0];
                sp_idx_d    = idx_c + IDX_W'(1);
                sp_mask_d   = lane_mask_c[7:4];
                sp_data_d   = lane_data_c[63:32];
                sp_lo_d     = rd_word_c;
            end else begin
                state_d      = RESP;
                resp_fault_d = fault_c;
                if (!req_we && !fault_c) begin
                    resp_rdata_d = extend(rd_word_c >> {req_addr[1:0], 3'b000}, req_funct3);
                end
            end
        end
    end

    // Split-access context, only meaningful while in SPLIT
    always_ff @(posedge clk) begin
        sp_we_q   <= sp_we_d;
        sp_f3_q   <= sp_f3_d;
        sp_off_q  <= sp_off_d;
        sp_idx_q  <= sp_idx_d;
        sp_mask_q <= sp_mask_d;
        sp_data_q <= sp_data_d;
        sp_lo_q   <= sp_lo_d;
    end
`else
    logic [3:0]  lane_mask_c;
    logic [31:0] lane_data_c;

    // Next state and registered outputs; priority encoding > misalign > range
    always_comb begin
        fault_c     = !enc_ok_c || misalign_c || !range_ok_c;
        lane_mask_c = size_mask_c << req_addr[1:0];
        lane_data_c = req_wdata << {req_addr[1:0], 3'b000};

        state_d         = IDLE;
        req_ready_d     = 1'b1;
        resp_rdata_d    = 32'd0;
        resp_fault_d    = 1'b0;
        resp_misalign_d = 1'b0;
        wr_en_c         = 1'b0;
        wr_idx_c        = idx_c;
        wr_mask_c       = lane_mask_c;
        wr_data_c       = lane_data_c;

        if (accept_c) begin
            state_d         = RESP;
            resp_fault_d    = fault_c;
            resp_misalign_d = enc_ok_c && misalign_c;
            wr_en_c         = req_we && !fault_c;
            if (!req_we && !fault_c) begin
                resp_rdata_d = extend(rd_word_c >> {req_addr[1:0], 3'b000}, req_funct3);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            resp_rdata_q    <= 32'd0;
            resp_fault_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_fault_q    <= resp_fault_d;
            resp_misalign_q <= resp_misalign_d;
        end
    end

    // Byte-lane write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask_c[b]) begin
                    mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_fault    = resp_fault_q;
    assign resp_misalign = resp_misalign_q;

endmodule
